// File: rtl/multicycle_control_if.sv
// multicycle_control_if
//   Control bus between the multicycle control FSM and the datapath.
//   master : the control FSM (samples opcode/mem_ready, drives all controls)
//   slave  : the datapath side (drives opcode/mem_ready, samples controls)
//   Signals: opcode[3:0], mem_ready, pc_write, pc_write_cond, branch_ne,
//            i_or_d, mem_read, mem_write, ir_write, reg_write, mem_to_reg,
//            alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_source[1:0],
//            state[3:0], retired[CNT_W-1:0], illegal.
interface multicycle_control_if #(
    parameter int unsigned CNT_W = 16
);
    logic [3:0]       opcode;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_write_cond;
    logic             branch_ne;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             reg_write;
    logic             mem_to_reg;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       pc_source;
    logic [3:0]       state;
    logic [CNT_W-1:0] retired;
    logic             illegal;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write,
               ir_write, reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
               pc_source, state, retired, illegal
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write,
               ir_write, reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
               pc_source, state, retired, illegal
    );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control
//   Main multicycle control FSM of the 16-bit processor (feeds aluControl).
//   Sequences fetch/decode/execute/memory/writeback; controls are decoded
//   from the registered state, with FETCH write enables gated by mem_ready.
// Ports
//   clk    : system clock, rising edge
//   rst_n  : asynchronous reset, active low
//   bus    : multicycle_control_if.master (opcode/mem_ready in, controls,
//            debug state, retired counter and illegal flag out)
// Parameters
//   CNT_W  : width of the retired-instruction counter
// Build option
//   CTRL_ILLEGAL_TRAP_EN : illegal opcodes go to TRAP and set sticky illegal;
//                          otherwise they retire as a NOP.
module multicycle_control #(
    parameter int unsigned CNT_W = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    multicycle_control_if.master bus
);
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_RTEXE  = 4'd7,
        S_RTWB   = 4'd8,
        S_IMMEXE = 4'd9,
        S_IMMWB  = 4'd10,
        S_BRANCH = 4'd11,
        S_JUMP   = 4'd12,
        S_HALT   = 4'd13,
        S_TRAP   = 4'd14
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic             illegal_q;
    logic             trap_set;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            retired_q <= retired_d;
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        illegal_q <= 1'b0;
        else if (trap_set) illegal_q <= 1'b1;
    end
    assign bus.illegal = illegal_q;
`else
    assign bus.illegal = 1'b0;
`endif

    assign bus.state   = state_q;
    assign bus.retired = retired_q;
    assign retired_d   = retire ? retired_q + CNT_W'(1) : retired_q;

    always_comb begin
        state_d           = state_q;
        op_d              = op_q;
        retire            = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
        trap_set          = 1'b0;
`endif
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.branch_ne     = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.reg_write     = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'd0;
        bus.alu_op        = 2'd0;
        bus.pc_source     = 2'd0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'd1;
                // IR/PC load only on the ready cycle so a stalled fetch
                // cannot increment the PC twice.
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                bus.alu_src_b = 2'd3;
                op_d          = bus.opcode;
                case (bus.opcode)
                    4'd0:       state_d = S_RTEXE;
                    4'd1, 4'd6: state_d = S_IMMEXE;
                    4'd2, 4'd3: state_d = S_MEMADR;
                    4'd4, 4'd5: state_d = S_BRANCH;
                    4'd7:       state_d = S_JUMP;
                    4'd15: begin
                        state_d = S_HALT;
                        retire  = 1'b1;
                    end
                    default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                        state_d  = S_TRAP;
                        trap_set = 1'b1;
`else
                        state_d  = S_FETCH;
                        retire   = 1'b1;
`endif
                    end
                endcase
            end
            S_MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'd2;
                state_d       = (op_q == 4'd3) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                bus.i_or_d   = 1'b1;
                bus.mem_read = 1'b1;
                if (bus.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                retire         = 1'b1;
                state_d        = S_FETCH;
            end
            S_MEMWR: begin
                bus.i_or_d    = 1'b1;
                bus.mem_write = 1'b1;
                if (bus.mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_RTEXE: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'd2;
                state_d       = S_RTWB;
            end
            S_IMMEXE: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'd2;
                bus.alu_op    = (op_q == 4'd6) ? 2'd3 : 2'd0;
                state_d       = S_IMMWB;
            end
            S_RTWB, S_IMMWB: begin
                bus.reg_write = 1'b1;
                retire        = 1'b1;
                state_d       = S_FETCH;
            end
            S_BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = 2'd1;
                bus.pc_write_cond = 1'b1;
                bus.pc_source     = 2'd1;
                bus.branch_ne     = (op_q == 4'd5);
                retire            = 1'b1;
                state_d           = S_FETCH;
            end
            S_JUMP: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = 2'd2;
                retire        = 1'b1;
                state_d       = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_TRAP: state_d = S_TRAP;
`endif
            default: state_d = S_IDLE;
        endcase
    end
endmodule
